// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alarm_sequencer
// Purpose : Alarm clock ring/snooze/timeout sequencer driven by a 1 Hz tick.
// Rev     : 1.0  initial release
// ============================================================================
module alarm_sequencer #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              tick_sec,
  input  logic                              bud_en,
  input  logic [3:0]                        hourdec_now,
  input  logic [3:0]                        hourone_now,
  input  logic [3:0]                        mindec_now,
  input  logic [3:0]                        minone_now,
  input  logic [3:0]                        hourdec_bud,
  input  logic [3:0]                        hourone_bud,
  input  logic [3:0]                        mindec_bud,
  input  logic [3:0]                        minone_bud,
  input  logic                              stop_i,
  input  logic                              snooze_i,
  output logic                              bud_on,
  output logic [1:0]                        state_o,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt_o,
  output logic                              missed_o
);

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SN_W    = $clog2(MAX_SNOOZE + 1);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [SN_W-1:0]  SN_LIMIT    = SN_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sec_cnt;
  logic             match;
  logic             match_d;
  logic             match_rise;

  assign match      = ({hourdec_now, hourone_now, mindec_now, minone_now} ==
                       {hourdec_bud, hourone_bud, mindec_bud, minone_bud});
  assign match_rise = match & ~match_d;
  assign state_o    = state;

  // match_d resets high so a time already equal to the alarm at release is not an edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      bud_on       <= 1'b0;
      missed_o     <= 1'b0;
      snooze_cnt_o <= '0;
      sec_cnt      <= '0;
      match_d      <= 1'b1;
    end else begin
      match_d  <= match;
      missed_o <= 1'b0;
      if (!bud_en) begin
        state        <= IDLE;
        bud_on       <= 1'b0;
        sec_cnt      <= '0;
        snooze_cnt_o <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARMED;
          end
          ARMED: begin
            if (match_rise) begin
              state        <= RINGING;
              bud_on       <= 1'b1;
              sec_cnt      <= '0;
              snooze_cnt_o <= '0;
            end
          end
          RINGING: begin
            if (stop_i) begin
              state        <= ARMED;
              bud_on       <= 1'b0;
              sec_cnt      <= '0;
              snooze_cnt_o <= '0;
            end else if (tick_sec && (sec_cnt == RING_LAST)) begin
              state        <= ARMED;
              bud_on       <= 1'b0;
              missed_o     <= 1'b1;
              sec_cnt      <= '0;
              snooze_cnt_o <= '0;
            end else if (snooze_i && (snooze_cnt_o < SN_LIMIT)) begin
              state        <= SNOOZE;
              bud_on       <= 1'b0;
              sec_cnt      <= '0;
              snooze_cnt_o <= snooze_cnt_o + 1'b1;
            end else if (tick_sec) begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
          SNOOZE: begin
            if (stop_i) begin
              state        <= ARMED;
              sec_cnt      <= '0;
              snooze_cnt_o <= '0;
            end else if (tick_sec && (sec_cnt == SNOOZE_LAST)) begin
              state   <= RINGING;
              bud_on  <= 1'b1;
              sec_cnt <= '0;
            end else if (tick_sec) begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_sequencer
// Purpose : Scoreboard bench for alarm_sequencer against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alarm_sequencer;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int MAX_SNOOZE = 3;
  localparam int SN_W       = $clog2(MAX_SNOOZE + 1);

  logic clk, rstn, tick_sec, bud_en, stop_i, snooze_i;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic bud_on, missed_o;
  logic [1:0] state_o;
  logic [SN_W-1:0] snooze_cnt_o;

  alarm_sequencer #(
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rstn(rstn), .tick_sec(tick_sec), .bud_en(bud_en),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .hourdec_bud(hourdec_bud), .hourone_bud(hourone_bud),
    .mindec_bud(mindec_bud), .minone_bud(minone_bud),
    .stop_i(stop_i), .snooze_i(snooze_i),
    .bud_on(bud_on), .state_o(state_o), .snooze_cnt_o(snooze_cnt_o), .missed_o(missed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit on;
    int snz;
    bit miss;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc_no  = 0;

  // Reference model: mode names follow the state_o numbering
  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;
  int m_mode, m_elapsed, m_snz;
  bit m_prev_match, m_ring, m_missed;

  task automatic model_reset();
    m_mode = M_IDLE; m_elapsed = 0; m_snz = 0;
    m_prev_match = 1'b1; m_ring = 1'b0; m_missed = 1'b0;
  endtask

  task automatic model_step();
    bit now_match, fresh;
    now_match = ({hourdec_now, hourone_now, mindec_now, minone_now} ==
                 {hourdec_bud, hourone_bud, mindec_bud, minone_bud});
    fresh = now_match && !m_prev_match;
    m_prev_match = now_match;
    m_missed = 1'b0;
    if (!bud_en) begin
      m_mode = M_IDLE; m_ring = 1'b0; m_elapsed = 0; m_snz = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (fresh) begin
        m_mode = M_RING; m_ring = 1'b1; m_elapsed = 0; m_snz = 0;
      end
    end else if (m_mode == M_RING) begin
      if (stop_i) begin
        m_mode = M_ARMED; m_ring = 1'b0; m_elapsed = 0; m_snz = 0;
      end else if (tick_sec && m_elapsed + 1 == RING_SEC) begin
        m_mode = M_ARMED; m_ring = 1'b0; m_missed = 1'b1; m_elapsed = 0; m_snz = 0;
      end else if (snooze_i && m_snz < MAX_SNOOZE) begin
        m_mode = M_SNOOZE; m_ring = 1'b0; m_elapsed = 0; m_snz++;
      end else if (tick_sec) begin
        m_elapsed++;
      end
    end else begin
      if (stop_i) begin
        m_mode = M_ARMED; m_elapsed = 0; m_snz = 0;
      end else if (tick_sec && m_elapsed + 1 == SNOOZE_SEC) begin
        m_mode = M_RING; m_ring = 1'b1; m_elapsed = 0;
      end else if (tick_sec) begin
        m_elapsed++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (int'(state_o) != e.st || bud_on !== e.on || int'(snooze_cnt_o) != e.snz ||
          missed_o !== e.miss) begin
        n_fail++;
        $display("FAIL sb cyc=%0d state act=%0d exp=%0d bud_on act=%0b exp=%0b snz act=%0d exp=%0d missed act=%0b exp=%0b",
                 cyc_no, state_o, e.st, bud_on, e.on, snooze_cnt_o, e.snz, missed_o, e.miss);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    model_step();
    e.st = m_mode; e.on = m_ring; e.snz = m_snz; e.miss = m_missed;
    sb.push_back(e);
    cyc_no++;
    #1;
  endtask

  task automatic pulse(input bit t, input bit st, input bit sn);
    tick_sec = t; stop_i = st; snooze_i = sn;
    cyc();
    tick_sec = 1'b0; stop_i = 1'b0; snooze_i = 1'b0;
  endtask

  task automatic set_now(input logic [15:0] v);
    {hourdec_now, hourone_now, mindec_now, minone_now} = v;
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk({tag, "_bud_on"}, int'(bud_on), 0);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_snz"}, int'(snooze_cnt_o), 0);
    chk({tag, "_missed"}, int'(missed_o), 0);
    model_reset();
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1; bud_en = 1'b0; tick_sec = 1'b0; stop_i = 1'b0; snooze_i = 1'b0;
    {hourdec_bud, hourone_bud, mindec_bud, minone_bud} = 16'h0730;
    set_now(16'h0729);
    model_reset();
    async_reset("por");

    // Match edge rings one clock after the time reaches 07:30
    bud_en = 1'b1;
    repeat (3) pulse(0, 0, 0);
    set_now(16'h0730);
    repeat (3) pulse(0, 0, 0);

    // Unanswered ring times out on the 60th tick
    repeat (RING_SEC) pulse(1, 0, 0);
    repeat (2) pulse(0, 0, 0);

    // Re-ring, then exhaust snoozes; the extra snooze is ignored
    set_now(16'h0731); pulse(0, 0, 0);
    set_now(16'h0730); pulse(0, 0, 0);
    for (int k = 0; k < MAX_SNOOZE; k++) begin
      pulse(0, 0, 1);
      repeat (SNOOZE_SEC) pulse(1, 0, 0);
      pulse(0, 0, 0);
    end
    pulse(0, 0, 1);
    pulse(0, 0, 0);

    // Stop beats snooze on the same clock
    pulse(0, 1, 1);
    pulse(0, 0, 0);

    // Arming while already matching does not ring; a later edge does
    bud_en = 1'b0; pulse(0, 0, 0);
    bud_en = 1'b1;
    repeat (5) pulse(0, 0, 0);
    set_now(16'h0731); pulse(0, 0, 0);
    set_now(16'h0730); repeat (2) pulse(0, 0, 0);

    // Reset mid-snooze, released while time equals alarm
    pulse(0, 0, 1);
    repeat (5) pulse(1, 0, 0);
    async_reset("rst_snooze");
    repeat (5) pulse(0, 0, 0);

    // Reset mid-ring drops the ring command without a clock
    set_now(16'h0731); pulse(0, 0, 0);
    set_now(16'h0730); repeat (2) pulse(0, 0, 0);
    async_reset("rst_ring");
    repeat (2) pulse(0, 0, 0);

    // Randomised phase
    for (int i = 0; i < 4000; i++) begin
      if (bud_en) begin
        if ($urandom_range(0, 299) == 0) bud_en = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        bud_en = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 4) == 0) set_now(16'($urandom_range(0, 65535)));
        else if ({hourdec_now, hourone_now, mindec_now, minone_now} == 16'h0730) set_now(16'h0731);
        else set_now(16'h0730);
      end
      pulse(1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
